// File: rtl/pc_gen_pkg.sv
// Shared constants for the IF-stage program-counter generator.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        PCSRC_NORMAL  = 3'd0,
        PCSRC_BRANCH  = 3'd1,
        PCSRC_JUMP    = 3'd2,
        PCSRC_REGA    = 3'd3,
        PCSRC_RETPRED = 3'd4
    } pcsrc_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_ILLOP_PC = 32'h8000_0004;
    localparam logic [31:0] DEFAULT_XADR_PC  = 32'h8000_0008;
    localparam int unsigned DEFAULT_PC_STEP  = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with a top pointer and a saturating valid count.
module ras_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [XLEN-1:0]            push_data,
    output logic [XLEN-1:0]            top_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   top;
    logic            pop_eff;

    assign pop_eff  = pop && (count != '0);
    assign top_data = mem[top];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            top   <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && pop_eff) begin
            // Return consumed and call pushed together: replace the top in place.
            mem[top] <= push_data;
        end else if (push) begin
            mem[top + PW'(1)] <= push_data;
            top               <= top + PW'(1);
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop_eff) begin
            top   <= top - PW'(1);
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_gen_ras.sv
// IF-stage PC generator: exception vectors, EX redirect, stall, and RAS-predicted returns.
module pc_gen_ras
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
    parameter logic [XLEN-1:0] ILLOP_PC  = XLEN'(DEFAULT_ILLOP_PC),
    parameter logic [XLEN-1:0] XADR_PC   = XLEN'(DEFAULT_XADR_PC),
    parameter int unsigned     PC_STEP   = DEFAULT_PC_STEP,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           exc_illop,
    input  logic                           exc_xadr,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_pc,
    input  logic [2:0]                     pcsrc,
    input  logic                           branch_taken,
    input  logic [XLEN-1:0]                branch_target,
    input  logic [25:0]                    jump_index,
    input  logic [XLEN-1:0]                reg_target,
    input  logic                           ras_push,
    input  logic [XLEN-1:0]                ras_push_data,
    output logic [XLEN-1:0]                pc,
    output logic [XLEN-1:0]                pc_plus_step,
    output logic                           pred_ret,
    output logic                           flush,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

    logic            advance;
    logic            is_retpred;
    logic            ras_valid;
    logic            exc_any;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] pc_next;
    logic            pred_ret_next;

    assign exc_any      = exc_illop || exc_xadr;
    assign advance      = !(exc_any || redirect_valid || stall);
    assign is_retpred   = (pcsrc == PCSRC_RETPRED);
    assign ras_valid    = (ras_count != '0);
    assign pc_plus_step = pc + XLEN'(PC_STEP);

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .XLEN  (XLEN)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .clear     (exc_any),
        .push      (advance && ras_push),
        .pop       (advance && is_retpred),
        .push_data (ras_push_data),
        .top_data  (ras_top),
        .count     (ras_count)
    );

    always_comb begin
        pc_next       = pc_plus_step;
        pred_ret_next = 1'b0;
        if (exc_illop) begin
            pc_next = ILLOP_PC;
        end else if (exc_xadr) begin
            pc_next = XADR_PC;
        end else if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (stall) begin
            pc_next       = pc;
            pred_ret_next = pred_ret;
        end else begin
            case (pcsrc)
                PCSRC_BRANCH:  pc_next = branch_taken ? branch_target : pc_plus_step;
                PCSRC_JUMP:    pc_next = {pc_plus_step[XLEN-1:28], jump_index, 2'b00};
                PCSRC_REGA:    pc_next = reg_target;
                PCSRC_RETPRED: begin
                    if (ras_valid) begin
                        pc_next       = ras_top;
                        pred_ret_next = 1'b1;
                    end
                end
                default:       pc_next = pc_plus_step;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            pred_ret <= 1'b0;
            flush    <= 1'b0;
        end else begin
            pc       <= pc_next;
            pred_ret <= pred_ret_next;
            flush    <= exc_any || redirect_valid;
        end
    end

endmodule
